dmem_write_buffer: RTL

//  Posted-write buffer between the CPU data port and data memory. It drives the memory-side

---
 rtl/dmem_wbuf_pkg.sv | 19 +
 rtl/wbuf_fifo.sv | 73 +++++++
 rtl/dmem_write_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dmem_wbuf_pkg.sv
// Shared types and defaults for the data-memory posted-write buffer.
package dmem_wbuf_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 30;
  localparam int DEF_DW    = 32;

  // Word addresses the result-checking bench snoops on the memory bus
  localparam logic [29:0] TESTPORT  = 30'h40;
  localparam logic [29:0] PRINTPORT = 30'h1F5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RDONE = 2'd3
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer with head/tail/count and a youngest-match address search
// used for load forwarding.
module wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o,
  output logic [AW-1:0]            next_addr_o,
  output logic [DW-1:0]            next_data_o,
  input  logic [AW-1:0]            lookup_addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            hit_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, head_nx, slot;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CW'(1);
    end
  end

  assign head_nx     = head_q + PW'(1);
  assign count_o     = count_q;
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign next_addr_o = addr_q[head_nx];
  assign next_data_o = data_q[head_nx];

  // Walk from oldest to youngest so the last valid match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[slot] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[slot];
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the CPU data port and data memory: stores retire at once,
// loads forward from the buffer or wait for it to drain before reading memory.
//
// state | meaning
// IDLE  | bus quiet; waiting for a buffered store or a load miss
// WRITE | head entry on the bus, mem_write held until mem_ready
// READ  | load miss on the bus, mem_read held until mem_ready
// RDONE | captured read data returned to the CPU
module dmem_write_buffer
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_wen_i,
  input  logic          cpu_ren_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  wbuf_state_e   state_q, state_d;
  logic          push, pop, hit;
  logic [CW-1:0] count, count_push;
  logic [AW-1:0] head_addr, next_addr;
  logic [DW-1:0] head_data, next_data, hit_data;
  logic          mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;

  // Full is judged on the registered count, so a same-cycle pop never frees the slot.
  assign push       = cpu_wen_i && (count < CW'(DEPTH));
  assign count_push = count + CW'(push);

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (push),
    .push_addr_i   (cpu_addr_i),
    .push_data_i   (cpu_wdata_i),
    .pop_i         (pop),
    .count_o       (count),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .next_addr_o   (next_addr),
    .next_data_o   (next_data),
    .lookup_addr_i (cpu_addr_i),
    .hit_o         (hit),
    .hit_data_o    (hit_data)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    mem_write_d = mem_write_q;
    mem_read_d  = mem_read_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (count_push != '0) begin
          // An empty buffer takes the incoming store straight onto the bus.
          state_d     = ST_WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = (count != '0) ? head_addr : cpu_addr_i;
          mem_wdata_d = (count != '0) ? head_data : cpu_wdata_i;
        end else if (cpu_ren_i && !hit) begin
          state_d    = ST_READ;
          mem_read_d = 1'b1;
          mem_addr_d = cpu_addr_i;
        end
      end
      ST_WRITE: begin
        if (mem_ready_i) begin
          pop = 1'b1;
          if (count_push > CW'(1)) begin
            mem_addr_d  = (count >= CW'(2)) ? next_addr : cpu_addr_i;
            mem_wdata_d = (count >= CW'(2)) ? next_data : cpu_wdata_i;
          end else begin
            mem_write_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (mem_ready_i) begin
          rdata_d    = mem_rdata_i;
          mem_read_d = 1'b0;
          state_d    = ST_RDONE;
        end
      end
      ST_RDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    if (cpu_wen_i && (count == CW'(DEPTH))) begin
      cpu_stall_o = 1'b1;
    end else if (cpu_ren_i) begin
      if (state_q == ST_RDONE)  cpu_rdata_o = rdata_q;
      else if (hit)             cpu_rdata_o = hit_data;
      else                      cpu_stall_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_write_o = mem_write_q;
  assign mem_read_o  = mem_read_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
